// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer sharing one external
// combinational ALU between two requesters. Each accepted operation walks
// IDLE -> EXEC -> RESP. The result and flags are returned on the granted
// requester's response channel.
module alu_arbiter #(
  parameter int N        = 8,
  parameter int CTRL_W   = 4,
  parameter int MAX_CTRL = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [N-1:0]      req0_a,
  input  logic [N-1:0]      req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [N-1:0]      req1_a,
  input  logic [N-1:0]      req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [N-1:0]      rsp_y,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [N-1:0]      alu_y,
  input  logic [3:0]        alu_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                ptr;      // 0 favours requester 0, 1 favours requester 1
  logic                gid;      // id of the requester currently being served
  logic [N-1:0]        op_a, op_b;
  logic [CTRL_W-1:0]   op_ctrl;
  logic                grant0, grant1;
  logic                rsp_take;
  logic                ctrl_legal;

  // ALU inputs come only from the operand registers, so they stay stable
  // from EXEC through RESP.
  assign alu_a      = op_a;
  assign alu_b      = op_b;
  assign alu_ctrl   = op_ctrl;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign ctrl_legal = (op_ctrl <= CTRL_W'(MAX_CTRL));

  // Next-state, arbitration and response-consume decode.
  always_comb begin
    state_nxt = IDLE;
    grant0    = 1'b0;
    grant1    = 1'b0;
    rsp_take  = 1'b0;
    case (state)
      IDLE: begin
        grant0    = req0_valid && (!req1_valid || !ptr);
        grant1    = req1_valid && (!req0_valid ||  ptr);
        state_nxt = (grant0 || grant1) ? EXEC : IDLE;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        // Only the served requester's ready matters.
        rsp_take  = gid ? rsp1_ready : rsp0_ready;
        state_nxt = rsp_take ? IDLE : RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand capture, result capture and pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      gid        <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      rsp_y      <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant0) begin
            op_a    <= req0_a;
            op_b    <= req0_b;
            op_ctrl <= req0_ctrl;
            gid     <= 1'b0;
          end else if (grant1) begin
            op_a    <= req1_a;
            op_b    <= req1_b;
            op_ctrl <= req1_ctrl;
            gid     <= 1'b1;
          end
        end
        EXEC: begin
          if (ctrl_legal) begin
            rsp_y     <= alu_y;
            rsp_flags <= alu_flags;
            rsp_err   <= 1'b0;
          end else begin
            rsp_y     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b1;
          end
          rsp0_valid <= !gid;
          rsp1_valid <=  gid;
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            ptr        <= !gid;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural model of the
// external ALU attached to the alu_* ports.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_ctrl, req1_ctrl;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp_y;
  logic [3:0] rsp_flags;
  logic       rsp_err;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_ctrl, alu_flags;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.N(8), .CTRL_W(4), .MAX_CTRL(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // External ALU: shifts move B by A[2:0]; illegal codes give a junk pattern.
  logic [8:0] s;
  logic       c, v;
  always_comb begin
    s = '0; c = 1'b0; v = 1'b0;
    alu_y = '0;
    case (alu_ctrl)
      4'd0: begin s = {1'b0, alu_a} + {1'b0, alu_b}; alu_y = s[7:0]; c = s[8];
                  v = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]); end
      4'd1: begin s = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1; alu_y = s[7:0]; c = s[8];
                  v = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]); end
      4'd2: alu_y = alu_a & alu_b;
      4'd3: alu_y = alu_a | alu_b;
      4'd4: alu_y = ~(alu_a | alu_b);
      4'd5: alu_y = alu_a ^ alu_b;
      4'd6: alu_y = alu_b << alu_a[2:0];
      4'd7: alu_y = alu_b >> alu_a[2:0];
      4'd8: alu_y = $signed(alu_b) >>> alu_a[2:0];
      default: alu_y = 8'hAA;
    endcase
    alu_flags = (alu_ctrl > 4'd8) ? 4'hF : {alu_y[7], alu_y == 8'd0, c, v};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on requester id with rsp_ready given at RESP.
  task automatic run_op(input string tag, input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] ctrl, input logic [7:0] ey, input logic [3:0] ef,
                        input logic ee);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl; end
    #1;
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk({tag, "_exec_norsp"}, {rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
    chk({tag, "_alu_a"}, alu_a, a);
    tick();
    chk({tag, "_rspv"}, {rsp1_valid, rsp0_valid}, id ? 2'b10 : 2'b01);
    chk({tag, "_y"}, rsp_y, ey);
    chk({tag, "_flags"}, rsp_flags, ef);
    chk({tag, "_err"}, rsp_err, ee);
    if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk({tag, "_cleared"}, {rsp1_valid, rsp0_valid}, 0);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_rspv", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rsp", {rsp_y, rsp_flags, rsp_err}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_ctrl}, 0);

    // Basic add, signed-overflow add, subtract
    run_op("add0", 1'b0, 8'h02, 8'h02, 4'd0, 8'h04, 4'b0000, 1'b0);
    run_op("add1", 1'b1, 8'h7F, 8'h04, 4'd0, 8'h83, 4'b1001, 1'b0);
    run_op("sub0", 1'b0, 8'h02, 8'h04, 4'd1, 8'hFE, 4'b1000, 1'b0);

    // Both valid continuously from reset, rsp_ready tied high: 0,1,0,1
    reset = 1'b1; tick(); reset = 1'b0;
    req0_valid = 1; req0_a = 8'd1; req0_b = 8'd1; req0_ctrl = 4'd0;
    req1_valid = 1; req1_a = 8'd3; req1_b = 8'd5; req1_ctrl = 4'd0;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      chk("rr_ready", {req0_ready, req1_ready},
          {(cyc % 3 == 0) && ((cyc / 3) % 2 == 0), (cyc % 3 == 0) && ((cyc / 3) % 2 == 1)});
      chk("rr_rspv", {rsp0_valid, rsp1_valid},
          {(cyc % 3 == 2) && ((cyc / 3) % 2 == 0), (cyc % 3 == 2) && ((cyc / 3) % 2 == 1)});
      if (cyc % 3 == 2) chk("rr_y", rsp_y, ((cyc / 3) % 2 == 0) ? 8'd2 : 8'd8);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    tick();

    // Backpressure on rsp0; req1 waits; rsp1_ready must be ignored
    req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20; req0_ctrl = 4'd0;
    req1_valid = 1; req1_a = 8'h01; req1_b = 8'h01; req1_ctrl = 4'd0;
    rsp1_ready = 1;
    #1;
    chk("bp_grant", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 0;
    tick();
    for (int cyc = 0; cyc < 5; cyc++) begin
      chk("bp_hold_v", {rsp0_valid, rsp1_valid}, 2'b10);
      chk("bp_hold_y", {rsp_y, rsp_flags, rsp_err}, {8'h30, 4'b0000, 1'b0});
      chk("bp_no_req1", req1_ready, 0);
      tick();
    end
    rsp0_ready = 1;
    #1;
    chk("bp_still_resp", req1_ready, 0);
    tick();
    rsp0_ready = 0;
    chk("bp_released", {rsp0_valid, req1_ready}, 2'b01);
    tick();
    req1_valid = 0;
    tick();
    chk("bp_rsp1", {rsp1_valid, rsp_y}, {1'b1, 8'h02});
    tick();
    rsp1_ready = 0;
    chk("bp_rsp1_clr", rsp1_valid, 0);

    // Illegal ctrl, then legal arithmetic shift right
    run_op("illegal", 1'b0, 8'h02, 8'h02, 4'd12, 8'h00, 4'b0000, 1'b1);
    run_op("sra", 1'b0, 8'h02, 8'hC1, 4'd8, 8'hF0, 4'b1000, 1'b0);

    // Reset during EXEC of req1 (pointer currently favours requester 1)
    req1_valid = 1; req1_a = 8'h05; req1_b = 8'h06; req1_ctrl = 4'd0;
    #1;
    chk("rx_grant", req1_ready, 1);
    tick();
    req1_valid = 0;
    #1;
    chk("rx_exec_alu", alu_a, 8'h05);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rx_rspv", {rsp0_valid, rsp1_valid}, 0);
    chk("rx_rsp", {rsp_y, rsp_flags, rsp_err}, 0);
    chk("rx_alu", {alu_a, alu_b, alu_ctrl}, 0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      chk("rx_no_rsp1", rsp1_valid, 0);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rx_ptr", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 0; req1_valid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
